load_store_unit: RTL

//  Sits between the execute stage and the word-wide data memory. Accepts one RV32I load/store request at a time.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-steered and extended.
module load_store_unit #(
  parameter int unsigned MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_dat,
  output logic        rd_en,
  output logic        wr_en,
  input  logic [31:0] m_rd_dat
);

  localparam int unsigned CNT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_q;
  logic [15:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        req_err;
  logic        rd_en_d, wr_en_d, rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d, m_addr_d, m_wr_dat_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic decode_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  assign req_err = decode_err(req_we, req_funct3, req_addr[1:0]);

  // Load formatting from the word currently on the memory read bus.
  always_comb begin
    ld_byte = m_rd_dat[{addr_q, 3'b000} +: 8];
    ld_half = m_rd_dat[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = m_rd_dat;
    endcase
  end

  // Sub-word store: overwrite only the addressed lane of the read word.
  always_comb begin
    merged = m_rd_dat;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 2'b00;
      wdata_q   <= 16'd0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      m_addr    <= 32'd0;
      m_wr_dat  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_en     <= rd_en_d;
      wr_en     <= wr_en_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      m_addr    <= m_addr_d;
      m_wr_dat  <= m_wr_dat_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[1:0];
        wdata_q  <= req_wdata[15:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    m_addr_d    = m_addr;
    m_wr_dat_d  = m_wr_dat;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            m_addr_d = {2'b00, req_addr[31:2]};
            if (req_we && (req_funct3 == 3'b010)) begin
              state_d    = S_WRITE;
              m_wr_dat_d = req_wdata;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        cnt_d = CNT_INIT;
        // A sub-word store merges in the cycle the read data arrives.
        state_d = (we_q && (MEM_RD_LATENCY == 1)) ? S_MERGE : S_WAIT;
      end
      S_WAIT: begin
        if (!we_q && (cnt_q == '0)) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end else if (we_q && (cnt_q == CNT_W'(1))) begin
          state_d = S_MERGE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MERGE: begin
        m_wr_dat_d = merged;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_en_d     = (state_d == S_READ);
    wr_en_d     = (state_d == S_WRITE);
    rsp_valid_d = (state_d == S_RESP);
  end

endmodule
